decode_stage: RTL

Registered, parametrised instruction-decode stage for the five-stage RISC-V pipeline, sitting between fetch (IF/ID) and execute (ID/EX). Extracts register and function fields, generates the sign-extended immediate for every base format, and classifies register usage for the hazard unit. Output is registered behind a valid/ready handshake with pipeline flush. Optional illegal-instruction detection is included.

---
 rtl/decode_pkg.sv | 65 ++++++
 rtl/decode_stage_imm_gen.sv | 31 +++
 rtl/decode_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RISC-V decode stage.
//   - base opcode constants (RV32I/RV64I)
//   - imm_type_e immediate-format code (IMM_I .. IMM_NONE)
//   - instruction field bit positions
//   - decode_t: the registered decoded bundle (excluding pc/imm, which are XLEN wide)
//   - imm_type_of(): opcode -> immediate format
package decode_pkg;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] OP_IMM32  = 7'h1B;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_OP32   = 7'h3B;

   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned RD_LSB     = 7;
   localparam int unsigned FUNC3_LSB  = 12;
   localparam int unsigned RS1_LSB    = 15;
   localparam int unsigned RS2_LSB    = 20;
   localparam int unsigned FUNC7_LSB  = 25;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_type_e;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] func3;
      logic [6:0] func7;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      imm_type_e  imm_type;
      logic       rs1_used;
      logic       rs2_used;
      logic       rd_we;
      logic       illegal;
   } decode_t;

   function automatic imm_type_e imm_type_of(input logic [6:0] op);
      imm_type_e t;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_IMM32: t = IMM_I;
         OP_STORE:                                       t = IMM_S;
         OP_BRANCH:                                      t = IMM_B;
         OP_LUI, OP_AUIPC:                               t = IMM_U;
         OP_JAL:                                         t = IMM_J;
         default:                                        t = IMM_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   instr    [31:0]    raw instruction word
//   imm_type imm_type_e format selected by the decoder
//   imm      [XLEN-1:0] immediate sign-extended from instr[31]; 0 for IMM_NONE
module imm_gen
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      // Signed size cast widens to XLEN by replicating bit 31.
      imm = XLEN'($signed(imm32));
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V instruction decode (IF/ID -> ID/EX).
// Ports:
//   clk, rst (sync, active high), flush (kills held + incoming instruction)
//   in_valid/in_ready/in_instr/in_pc      upstream handshake and payload
//   out_valid/out_ready                   downstream handshake
//   out_pc, out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd,
//   out_imm, out_imm_type, out_rs1_used, out_rs2_used, out_rd_we, out_illegal
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to enable illegal-instruction
// detection (out_illegal, rd_we suppression); otherwise out_illegal is 0.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_func3,
   output logic [6:0]      out_func7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_imm_type,
   output logic            out_rs1_used,
   output logic            out_rs2_used,
   output logic            out_rd_we,
   output logic            out_illegal
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] imm_q, imm_d;
   decode_t         dec_q, dec_d;

   decode_t         dec_new;
   imm_type_e       itype;
   logic [XLEN-1:0] imm_new;
   logic            accept;
   logic            is_r;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr    (in_instr),
      .imm_type (itype),
      .imm      (imm_new)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Combinational decode of the incoming instruction.
   always_comb begin
      itype            = imm_type_of(in_instr[RS1_LSB-9 -: 7]);
      is_r             = (in_instr[6:0] == OP_OP) || (in_instr[6:0] == OP_OP32);
      dec_new          = '0;
      dec_new.opcode   = in_instr[OPCODE_LSB +: 7];
      dec_new.func3    = in_instr[FUNC3_LSB  +: 3];
      dec_new.func7    = in_instr[FUNC7_LSB  +: 7];
      dec_new.rs1      = in_instr[RS1_LSB    +: 5];
      dec_new.rs2      = in_instr[RS2_LSB    +: 5];
      dec_new.rd       = in_instr[RD_LSB     +: 5];
      dec_new.imm_type = itype;
      dec_new.rs1_used = is_r || (itype inside {IMM_I, IMM_S, IMM_B});
      dec_new.rs2_used = is_r || (itype inside {IMM_S, IMM_B});
      dec_new.rd_we    = (is_r || (itype inside {IMM_I, IMM_U, IMM_J}))
                         && (in_instr[RD_LSB +: 5] != 5'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
      dec_new.illegal  = (in_instr[1:0] != 2'b11)
                         || (!is_r && (itype == IMM_NONE))
                         || (is_r && !((in_instr[FUNC7_LSB +: 7] == 7'h00)
                                    || (in_instr[FUNC7_LSB +: 7] == 7'h20)));
      if (dec_new.illegal) dec_new.rd_we = 1'b0;
`else
      dec_new.illegal  = 1'b0;
`endif
   end

   // Flush wins over accept; fields only load on a surviving accept.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      dec_d   = dec_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         pc_d    = in_pc;
         imm_d   = imm_new;
         dec_d   = dec_new;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q        <= 1'b0;
         pc_q           <= RESET_PC;
         imm_q          <= '0;
         dec_q          <= '0;
         dec_q.imm_type <= IMM_NONE;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         dec_q   <= dec_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_imm      = imm_q;
   assign out_opcode   = dec_q.opcode;
   assign out_func3    = dec_q.func3;
   assign out_func7    = dec_q.func7;
   assign out_rs1      = dec_q.rs1;
   assign out_rs2      = dec_q.rs2;
   assign out_rd       = dec_q.rd;
   assign out_imm_type = dec_q.imm_type;
   assign out_rs1_used = dec_q.rs1_used;
   assign out_rs2_used = dec_q.rs2_used;
   assign out_rd_we    = dec_q.rd_we;
   assign out_illegal  = dec_q.illegal;

endmodule
